// File: rtl/sample_test_arb.sv
// sample_test_arb
//   Round-robin arbiter sharing one sampletest unit between two sample
//   iterators (A and B). Each cycle at most one requester is granted; its
//   triangle/color/sample are muxed onto the sampletest R16 inputs. A
//   {vld, src} tag rides a PIPE_DEPTH-deep shift register alongside
//   sampletest so each R18 result is routed back to its requester.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   tri/color/sample_{a,b}_R16*   requester payloads
//   validSamp_{a,b}_R16H          request valid
//   halt_{a,b}_R16L               1 = request accepted this cycle (combinational)
//   tri/color/sample_R16*         muxed payload to sampletest
//   validSamp_R16H                valid to sampletest
//   hit_valid_R18H                sampletest hit result
//   hit_{a,b}_R18H                hit routed to A / B
//   done_{a,b}_R18H               R18 result belongs to A / B
//   src_R18H                      requester of R18 result (0 = A, 1 = B)
//
// Optional feature: define SAMPLE_TEST_ARB_STATS_EN to add saturating
//   32-bit counters hits_{a,b}_cnt and samples_{a,b}_cnt.
module sample_test_arb #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPE_DEPTH = 2,
  parameter int BURST      = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_a_R16S,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_b_R16S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]        color_a_R16U,
  input  logic        [COLORS-1:0][SIGFIG-1:0]        color_b_R16U,
  input  logic signed [1:0][SIGFIG-1:0]               sample_a_R16S,
  input  logic signed [1:0][SIGFIG-1:0]               sample_b_R16S,
  input  logic                                        validSamp_a_R16H,
  input  logic                                        validSamp_b_R16H,
  output logic                                        halt_a_R16L,
  output logic                                        halt_b_R16L,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]        color_R16U,
  output logic signed [1:0][SIGFIG-1:0]               sample_R16S,
  output logic                                        validSamp_R16H,
  input  logic                                        hit_valid_R18H,
  output logic                                        hit_a_R18H,
  output logic                                        hit_b_R18H,
  output logic                                        src_R18H,
  output logic                                        done_a_R18H,
  output logic                                        done_b_R18H
`ifdef SAMPLE_TEST_ARB_STATS_EN
  ,
  output logic [31:0]                                 hits_a_cnt,
  output logic [31:0]                                 hits_b_cnt,
  output logic [31:0]                                 samples_a_cnt,
  output logic [31:0]                                 samples_b_cnt
`endif
);

  localparam int              CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Configurations sampletest cannot be fed from: empty marker block so a
  // bad parameter set is visible in the elaborated hierarchy.
  if (PIPE_DEPTH < 1 || BURST < 1 || RADIX >= SIGFIG) begin : g_bad_cfg
  end

  logic             last_R;       // 0 = A, 1 = B
  logic [CNT_W-1:0] burst_cnt_R;
  logic             gnt_a, gnt_b;
  logic             stay, pick_b;

  // burst_cnt_R == 0 only after reset: no burst in progress, so the tie goes
  // to the requester that was not last granted (A, since last_R resets to B).
  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    stay   = (burst_cnt_R != '0) && (burst_cnt_R < BURST_C);
    pick_b = stay ? last_R : ~last_R;
    if (!rst) begin
      if (validSamp_a_R16H && !validSamp_b_R16H) begin
        gnt_a = 1'b1;
      end else if (validSamp_b_R16H && !validSamp_a_R16H) begin
        gnt_b = 1'b1;
      end else if (validSamp_a_R16H && validSamp_b_R16H) begin
        gnt_b = pick_b;
        gnt_a = ~pick_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_R      <= 1'b1;
      burst_cnt_R <= '0;
    end else if (gnt_a || gnt_b) begin
      if (gnt_b == last_R) begin
        if (burst_cnt_R != BURST_C) burst_cnt_R <= burst_cnt_R + ONE_C;
      end else begin
        last_R      <= gnt_b;
        burst_cnt_R <= ONE_C;
      end
    end
  end

  assign halt_a_R16L    = gnt_a;
  assign halt_b_R16L    = gnt_b;
  assign validSamp_R16H = gnt_a | gnt_b;
  assign tri_R16S       = gnt_b ? tri_b_R16S    : tri_a_R16S;
  assign color_R16U     = gnt_b ? color_b_R16U  : color_a_R16U;
  assign sample_R16S    = gnt_b ? sample_b_R16S : sample_a_R16S;

  // Tag shift register matching sampletest latency.
  logic [PIPE_DEPTH-1:0] vld_pipe;
  logic [PIPE_DEPTH-1:0] src_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      src_pipe <= '0;
    end else begin
      vld_pipe[0] <= validSamp_R16H;
      src_pipe[0] <= gnt_b;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        src_pipe[i] <= src_pipe[i-1];
      end
    end
  end

  assign src_R18H    = src_pipe[PIPE_DEPTH-1];
  assign done_a_R18H = vld_pipe[PIPE_DEPTH-1] & ~src_pipe[PIPE_DEPTH-1];
  assign done_b_R18H = vld_pipe[PIPE_DEPTH-1] &  src_pipe[PIPE_DEPTH-1];
  assign hit_a_R18H  = done_a_R18H & hit_valid_R18H;
  assign hit_b_R18H  = done_b_R18H & hit_valid_R18H;

`ifdef SAMPLE_TEST_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_a_cnt    <= '0;
      hits_b_cnt    <= '0;
      samples_a_cnt <= '0;
      samples_b_cnt <= '0;
    end else begin
      if (hit_a_R18H  && hits_a_cnt    != '1) hits_a_cnt    <= hits_a_cnt    + 32'd1;
      if (hit_b_R18H  && hits_b_cnt    != '1) hits_b_cnt    <= hits_b_cnt    + 32'd1;
      if (done_a_R18H && samples_a_cnt != '1) samples_a_cnt <= samples_a_cnt + 32'd1;
      if (done_b_R18H && samples_b_cnt != '1) samples_b_cnt <= samples_b_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_test_arb.sv
module tb_sample_test_arb;

  localparam int SIGFIG = 24;

  logic clk = 1'b0;
  logic rst;
  logic signed [2:0][2:0][SIGFIG-1:0] tri_a, tri_b, tri_o;
  logic        [2:0][SIGFIG-1:0]      col_a, col_b, col_o;
  logic signed [1:0][SIGFIG-1:0]      smp_a, smp_b, smp_o;
  logic va, vb, ha, hb, vs_o, hv;
  logic hit_a, hit_b, src, done_a, done_b;
`ifdef SAMPLE_TEST_ARB_STATS_EN
  logic [31:0] hits_a_cnt, hits_b_cnt, samples_a_cnt, samples_b_cnt;
`endif

  int ncmp = 0;
  int nfail = 0;
  int h1 = 0, h2 = 0;  // hand-given grants 1 and 2 cycles ago (0 none, 1 A, 2 B)

  always #5 clk = ~clk;

  sample_test_arb #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3),
                    .PIPE_DEPTH(2), .BURST(4)) dut (
    .clk(clk), .rst(rst),
    .tri_a_R16S(tri_a), .tri_b_R16S(tri_b),
    .color_a_R16U(col_a), .color_b_R16U(col_b),
    .sample_a_R16S(smp_a), .sample_b_R16S(smp_b),
    .validSamp_a_R16H(va), .validSamp_b_R16H(vb),
    .halt_a_R16L(ha), .halt_b_R16L(hb),
    .tri_R16S(tri_o), .color_R16U(col_o), .sample_R16S(smp_o),
    .validSamp_R16H(vs_o),
    .hit_valid_R18H(hv),
    .hit_a_R18H(hit_a), .hit_b_R18H(hit_b), .src_R18H(src),
    .done_a_R18H(done_a), .done_b_R18H(done_b)
`ifdef SAMPLE_TEST_ARB_STATS_EN
    , .hits_a_cnt(hits_a_cnt), .hits_b_cnt(hits_b_cnt),
    .samples_a_cnt(samples_a_cnt), .samples_b_cnt(samples_b_cnt)
`endif
  );

  task automatic chk(input string tag, input string what,
                     input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // One directed cycle: drive request inputs, check R16 grant/payload against
  // hand-given grant eg, and R18 outputs against the grant given 2 cycles ago.
  task automatic cyc(input logic a, input logic b, input logic hitv,
                     input int eg, input string tag);
    va = a; vb = b; hv = hitv;
    @(negedge clk);
    chk(tag, "halt_a", ha, eg == 1);
    chk(tag, "halt_b", hb, eg == 2);
    chk(tag, "validSamp", vs_o, eg != 0);
    chk(tag, "sample", smp_o, (eg == 2) ? smp_b : smp_a);
    chk(tag, "color", col_o, (eg == 2) ? col_b : col_a);
    chk(tag, "tri", tri_o, (eg == 2) ? tri_b : tri_a);
    chk(tag, "done_a", done_a, h2 == 1);
    chk(tag, "done_b", done_b, h2 == 2);
    chk(tag, "src", src, h2 == 2);
    chk(tag, "hit_a", hit_a, (h2 == 1) && hitv);
    chk(tag, "hit_b", hit_b, (h2 == 2) && hitv);
    @(posedge clk); #1;
    h2 = h1; h1 = eg;
  endtask

  // One reset cycle with requests asserted; nothing may be granted.
  task automatic rst_cyc(input logic a, input logic b, input string tag);
    rst = 1'b1; va = a; vb = b;
    @(negedge clk);
    chk(tag, "halt_a", ha, 1'b0);
    chk(tag, "halt_b", hb, 1'b0);
    chk(tag, "validSamp", vs_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; h1 = 0; h2 = 0;
  endtask

  initial begin
    for (int v = 0; v < 3; v++) begin
      for (int x = 0; x < 3; x++) begin
        tri_a[v][x] = 24'(v * 3 + x + 1);
        tri_b[v][x] = -24'(v * 3 + x + 100);
      end
      col_a[v] = 24'(16'h1000 + v);
      col_b[v] = 24'(16'h2000 + v);
    end
    smp_a[0] = 24'd5;  smp_a[1] = 24'd7;
    smp_b[0] = -24'd9; smp_b[1] = 24'd11;
    rst = 1'b1; va = 1'b0; vb = 1'b0; hv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: idle, nothing in flight, hit_valid ignored.
    cyc(0, 0, 1, 0, "reset_idle");
    cyc(0, 0, 1, 0, "reset_idle2");

    // A alone for 10 cycles; results in cycles 2..11.
    for (int i = 0; i < 10; i++) cyc(1, 0, (i % 2) == 1, 1, "a_alone");
    cyc(0, 0, 1, 0, "a_flush0");
    cyc(0, 0, 0, 0, "a_flush1");

    // Fresh arbitration: both valid gives A,A,A,A,B,B,B,B,A,A.
    rst_cyc(0, 0, "rst_pre_both");
    cyc(1, 1, 0, 1, "both0"); cyc(1, 1, 1, 1, "both1");
    cyc(1, 1, 1, 1, "both2"); cyc(1, 1, 0, 1, "both3");
    cyc(1, 1, 1, 2, "both4"); cyc(1, 1, 1, 2, "both5");
    cyc(1, 1, 0, 2, "both6"); cyc(1, 1, 1, 2, "both7");
    cyc(1, 1, 1, 1, "both8"); cyc(1, 1, 1, 1, "both9");
    cyc(0, 0, 0, 0, "both_flush0");
    cyc(0, 0, 0, 0, "both_flush1");

    // Routing: alternating single requests; sampletest reports A hits only.
    cyc(1, 0, 0, 1, "route0"); cyc(0, 1, 0, 2, "route1");
    cyc(1, 0, 1, 1, "route2"); cyc(0, 1, 0, 2, "route3");
    cyc(1, 0, 1, 1, "route4"); cyc(0, 1, 0, 2, "route5");
    cyc(0, 0, 1, 0, "route6"); cyc(0, 0, 0, 0, "route7");

    // Drop mid-burst: A,A, A drops -> B(cnt 1), then B continues to 4.
    cyc(1, 0, 0, 1, "drop0"); cyc(1, 0, 0, 1, "drop1");
    cyc(0, 1, 1, 2, "drop2"); cyc(1, 1, 1, 2, "drop3");
    cyc(1, 1, 1, 2, "drop4"); cyc(1, 1, 1, 2, "drop5");
    cyc(1, 1, 0, 1, "drop6"); cyc(1, 1, 1, 1, "drop7");
    cyc(0, 0, 1, 0, "drop_flush0");
    cyc(0, 0, 1, 0, "drop_flush1");

    // Reset mid-flight: two accepts, reset, no stale results; A wins first tie.
    cyc(1, 0, 1, 1, "mid0"); cyc(1, 0, 1, 1, "mid1");
    rst_cyc(1, 1, "mid_rst");
    cyc(1, 1, 1, 1, "post0"); cyc(1, 1, 1, 1, "post1");
    cyc(0, 0, 1, 0, "post2"); cyc(0, 0, 1, 0, "post3");

`ifdef SAMPLE_TEST_ARB_STATS_EN
    // Stats: 5 A samples, 3 of which hit.
    rst_cyc(0, 0, "stats_rst");
    cyc(1, 0, 0, 1, "st0"); cyc(1, 0, 0, 1, "st1");
    cyc(1, 0, 1, 1, "st2"); cyc(1, 0, 0, 1, "st3");
    cyc(1, 0, 1, 1, "st4"); cyc(0, 0, 0, 0, "st5");
    cyc(0, 0, 1, 0, "st6");
    @(negedge clk);
    chk("stats", "samples_a", samples_a_cnt, 32'd5);
    chk("stats", "hits_a", hits_a_cnt, 32'd3);
    chk("stats", "samples_b", samples_b_cnt, 32'd0);
    chk("stats", "hits_b", hits_b_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sample_test_arb.md
# sample_test_arb

Two-requester round-robin arbiter that shares one `sampletest` unit between two sample iterators, for example two `test_iterator` instances working on different triangles. Each cycle it selects one requester's triangle, color and sample and drives them onto the sampletest R16 inputs. A source tag travels alongside the sampletest pipeline so that each R18 hit result is routed back to the requester that issued it. It sits between the iterators and sampletest, and it replaces the direct iterator-to-sampletest connection.

## Interface
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels
- PIPE_DEPTH, 2, sampletest latency R16→R18 in cycles; must be ≥1
- BURST, 4, maximum consecutive grants to one requester while the other is waiting; must be ≥1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tri_a_R16S / tri_b_R16S  in  [VERTS][AXIS]×SIGFIG signed  triangle of requester A / B
- color_a_R16U / color_b_R16U  in  [COLORS]×SIGFIG  color of A / B
- sample_a_R16S / sample_b_R16S  in  [2]×SIGFIG signed  sample location of A / B
- validSamp_a_R16H / validSamp_b_R16H  in  1  request valid from A / B
- halt_a_R16L / halt_b_R16L  out  1  low = requester must hold; high = request accepted this cycle
- tri_R16S, color_R16U, sample_R16S  out  same widths  muxed payload to sampletest
- validSamp_R16H  out  1  valid to sampletest
- hit_valid_R18H  in  1  sampletest hit result
- hit_a_R18H / hit_b_R18H  out  1  hit routed to A / B
- src_R18H  out  1  requester of the R18 result (0 = A, 1 = B)
- done_a_R18H / done_b_R18H  out  1  R18 result belongs to A / B, whether or not it hit

## Operation
- Grant is combinational from validSamp_a/b and the registered state. Only one requester is granted per cycle.
- State registers:
  - last_R: most recent granted requester; reset value 1 (B), so A wins the first tie.
  - burst_cnt_R: consecutive grants to last_R; reset value 0, width clog2(BURST+1).
- Grant rules:
  - Only one requester valid: grant it. burst_cnt is ignored.
  - Both valid and burst_cnt_R < BURST: grant last_R (stay).
  - Both valid and burst_cnt_R == BURST: grant the other requester.
  - Neither valid: no grant; validSamp_R16H = 0; state holds.
- Counter update:
  - Grant to the same requester as last_R: burst_cnt_R increments, saturating at BURST.
  - Grant to the other requester: last_R flips and burst_cnt_R = 1.
- halt_x_R16L = 1 exactly when requester x is granted; otherwise 0, even when x is not valid.
- Payload mux selects the granted requester. Payload is A when nothing is granted; it is a don't-care because validSamp_R16H = 0.
- Tag pipeline, PIPE_DEPTH stages, each holding {vld, src}:
  - Stage 0 input: {validSamp_R16H, grant == B}.
  - Final stage drives src_R18H.
  - done_x_R18H = vld && src == x.
  - hit_x_R18H = done_x_R18H && hit_valid_R18H.
- No backpressure exists downstream; sampletest is fixed-latency and every accepted sample yields exactly one done pulse.

## Timing
- Request to accept: 0 cycles; halt is combinational in the R16 cycle.
- Accept to result: PIPE_DEPTH cycles; done/hit are asserted in cycle t+PIPE_DEPTH for an accept in cycle t.
- Throughput: 1 sample per cycle in aggregate.
- Reset values:
  - All tag stages vld = 0, src = 0.
  - hit_*, done_*, src_R18H = 0.
  - last_R = 1, burst_cnt_R = 0.
- During reset: halt_a/b_R16L = 0 and validSamp_R16H = 0.
- Reset mid-operation: in-flight tags are cleared, so no done/hit pulse appears for samples accepted before reset.
- Simultaneous arrival, both valid, both idle: A is granted first.
- A requester that drops valid mid-burst loses its remaining burst. On return it is arbitrated by the rules above.

## Configuration
- SAMPLE_TEST_ARB_STATS_EN defined:
  - Adds outputs hits_a_cnt / hits_b_cnt (32-bit each) and samples_a_cnt / samples_b_cnt (32-bit each).
  - Each counter increments on hit_x_R18H or done_x_R18H respectively.
  - Counters saturate at 2^32−1 and reset to 0.
- Macro not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **A alone:** validSamp_a held high for 10 cycles, B idle, PIPE_DEPTH = 2. Expect halt_a_R16L = 1 on all 10 cycles and done_a_R18H pulsing in cycles 2–11. hit_a_R18H must mirror hit_valid_R18H; hit_b_R18H and done_b_R18H stay 0.
- **Both valid, BURST = 4:** expect grant sequence A,A,A,A,B,B,B,B,A… and halt_b_R16L = 0 on exactly the cycles A is granted.
- **Routing:** A sample inside its triangle, B sample outside, alternating grants. Expect hit_a_R18H = 1 with src_R18H = 0 for every A result, and hit_b_R18H = 0 with done_b_R18H = 1 for every B result.
- **Drop mid-burst:** A granted twice, then A drops valid for 1 cycle while B is valid. Expect B granted with burst_cnt = 1; when A returns, B continues until burst_cnt = 4.
- **Reset mid-flight:** accept 2 samples, assert rst for 1 cycle. Expect no done/hit pulses afterwards, and the first grant after reset goes to A when both are valid.
- **Stats (with SAMPLE_TEST_ARB_STATS_EN):** 5 A samples with 3 hits. Expect samples_a_cnt = 5, hits_a_cnt = 3, and both B counters = 0.
